concat_stream_buffer: RTL and testbench
=======================================

CONCAT_STREAM_BUFFER -- requirements
Module: concat_stream_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed word width.
REQ-002 SHALL have parameter X_LEN, default 6, number of input-vector (x_t) words.
REQ-003 SHALL have parameter H_LEN, default 64, number of hidden-state (h_{t-1}) words; DEPTH = X_LEN + H_LEN.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, width of all address ports; DEPTH <= 2^ADDR_WIDTH.
REQ-005 SHALL have ports, clock and reset first; one clock, reset asynchronous and active-high:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
  x_wr_en  in  1  write x word
  x_wr_addr  in  ADDR_WIDTH  x word index 0..X_LEN-1
  x_wr_data  in  DATA_WIDTH  signed x word
  h_wr_en  in  1  write h word
  h_wr_addr  in  ADDR_WIDTH  h word index 0..H_LEN-1
  h_wr_data  in  DATA_WIDTH  signed h word
  swap  in  1  pulse: exchange write and read banks
  rd_start  in  1  pulse: stream full concatenated vector from read bank
  rd_data  out  DATA_WIDTH  signed streamed word
  rd_valid  out  1  rd_data valid
  rd_last  out  1  marks word DEPTH-1
  rd_busy  out  1  stream in progress
  wr_bank  out  1  bank index currently written

Function
REQ-006 SHALL hold two banks of DEPTH signed DATA_WIDTH words; vector layout per bank: x at 0..X_LEN-1, h at X_LEN..DEPTH-1.
REQ-007 SHALL write x_wr_data to bank wr_bank, location x_wr_addr, at the edge where x_wr_en=1 and x_wr_addr < X_LEN; out-of-range writes ignored.
REQ-008 SHALL write h_wr_data to bank wr_bank, location X_LEN + h_wr_addr, when h_wr_en=1 and h_wr_addr < H_LEN; out-of-range ignored.
REQ-009 SHALL accept x and h writes in the same cycle, both taking effect.
REQ-010 SHALL read only from bank !wr_bank; the read bank is never written.
REQ-011 SHALL implement states IDLE and STREAM.
REQ-012 IDLE: rd_start=1 at edge k -> STREAM, read counter 0; rd_start while STREAM ignored.
REQ-013 STREAM: rd_valid=1 with rd_data = word i at edges k+1+i, i = 0..DEPTH-1; no gaps; rd_last=1 only with word DEPTH-1.
REQ-014 rd_busy SHALL be 1 from edge k until edge k+DEPTH inclusive, then 0; returns to IDLE at edge k+DEPTH, so a new rd_start then is accepted and its first word follows at k+DEPTH+1.
REQ-015 rd_valid, rd_last SHALL be 0 in cycles with no word; rd_data holds last value when not valid.
REQ-016 swap in IDLE SHALL toggle wr_bank at that edge.
REQ-017 swap during STREAM SHALL set a pending flag; toggle occurs at the edge issuing the rd_last word; multiple swaps while pending collapse to one toggle.
REQ-018 swap and rd_start in the same IDLE cycle: bank toggles first; stream reads the post-swap read bank (the bank just written).
REQ-019 writes coincident with a swap edge SHALL go to the pre-swap wr_bank.

Reset
REQ-020 rst=1 SHALL immediately force: state IDLE, wr_bank=0, pending swap cleared, read counter 0, rd_data=0, rd_valid=0, rd_last=0, rd_busy=0.
REQ-021 Memory contents SHALL not be reset (distributed RAM).
REQ-022 rst asserted mid-stream SHALL abort the stream with no further rd_valid; rd_start is accepted on the first edge after rst deasserts.

Verification
REQ-023 Reset: rst pulse mid-stream at word 10 -> rd_valid, rd_busy, wr_bank all 0 same cycle; no further words.
REQ-024 Fill: write x[i]=i+1 (i=0..5), h[j]=-(j+1) (j=0..63), swap, rd_start -> 70 words 1..6,-1..-64, contiguous, rd_last on word 69, rd_busy low after.
REQ-025 Ping-pong: during a stream of bank 1, write h[0]=0x7FFF to bank 0 -> streamed data unaffected; after swap+rd_start word 6 = 0x7FFF.
REQ-026 Deferred swap: swap pulsed twice at stream words 5 and 20 -> wr_bank toggles exactly once, at rd_last edge.
REQ-027 Boundaries: x_wr_addr=6, h_wr_addr=64, simultaneous x/h writes to last locations -> out-of-range ignored, both in-range words stored.
REQ-028 Same-cycle swap+rd_start in IDLE -> stream returns data of the bank written before the swap.

Source files
------------

// File: rtl/concat_stream_buffer.sv
// Ping-pong store for the concatenated vector [x_t ; h_{t-1}]: one bank is filled
// word by word while the other streams out all DEPTH words, one per cycle.
module concat_stream_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int X_LEN      = 6,
    parameter int H_LEN      = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x_wr_en,
    input  logic [ADDR_WIDTH-1:0]        x_wr_addr,
    input  logic signed [DATA_WIDTH-1:0] x_wr_data,
    input  logic                         h_wr_en,
    input  logic [ADDR_WIDTH-1:0]        h_wr_addr,
    input  logic signed [DATA_WIDTH-1:0] h_wr_data,
    input  logic                         swap,
    input  logic                         rd_start,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         rd_valid,
    output logic                         rd_last,
    output logic                         rd_busy,
    output logic                         wr_bank
);

    localparam int DEPTH = X_LEN + H_LEN;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]      H_BASE   = IDX_W'(X_LEN);
    localparam logic [ADDR_WIDTH:0]   X_LIMIT  = (ADDR_WIDTH + 1)'(X_LEN);
    localparam logic [ADDR_WIDTH:0]   H_LIMIT  = (ADDR_WIDTH + 1)'(H_LEN);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0] mem [2][DEPTH];

    logic [IDX_W-1:0] rd_cnt, rd_cnt_nxt;
    logic [IDX_W-1:0] x_idx, h_idx;
    logic             x_wr_ok, h_wr_ok;
    logic             wr_bank_nxt;
    logic             swap_pend, swap_pend_nxt;
    logic             issue, issue_last;

    assign x_wr_ok = x_wr_en && ({1'b0, x_wr_addr} < X_LIMIT);
    assign h_wr_ok = h_wr_en && ({1'b0, h_wr_addr} < H_LIMIT);
    assign x_idx   = IDX_W'(x_wr_addr);
    assign h_idx   = H_BASE + IDX_W'(h_wr_addr);

    // Writes always land in the bank selected before any toggle on this edge.
    always_ff @(posedge clk) begin
        if (x_wr_ok) begin
            mem[wr_bank][x_idx] <= x_wr_data;
        end
        if (h_wr_ok) begin
            mem[wr_bank][h_idx] <= h_wr_data;
        end
    end

    // A swap seen mid-stream is held until the last word is issued, so the
    // bank being read never changes underneath an active stream.
    always_comb begin
        state_nxt     = state;
        rd_cnt_nxt    = rd_cnt;
        wr_bank_nxt   = wr_bank;
        swap_pend_nxt = swap_pend;
        issue         = 1'b0;
        issue_last    = 1'b0;

        case (state)
            IDLE: begin
                if (swap) begin
                    wr_bank_nxt = ~wr_bank;
                end
                if (rd_start) begin
                    state_nxt  = STREAM;
                    rd_cnt_nxt = '0;
                end
            end

            STREAM: begin
                issue = 1'b1;
                if (rd_cnt == LAST_IDX) begin
                    issue_last    = 1'b1;
                    rd_cnt_nxt    = '0;
                    swap_pend_nxt = 1'b0;
                    if (swap_pend || swap) begin
                        wr_bank_nxt = ~wr_bank;
                    end
                    state_nxt = rd_start ? STREAM : IDLE;
                end else begin
                    rd_cnt_nxt = rd_cnt + 1'b1;
                    if (swap) begin
                        swap_pend_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            wr_bank   <= 1'b0;
            swap_pend <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_cnt    <= rd_cnt_nxt;
            wr_bank   <= wr_bank_nxt;
            swap_pend <= swap_pend_nxt;
            rd_valid  <= issue;
            rd_last   <= issue_last;
            if (issue) begin
                rd_data <= mem[~wr_bank][rd_cnt];
            end
        end
    end

    assign rd_busy = (state == STREAM);

endmodule

// File: tb/tb_concat_stream_buffer.sv
// Bench for concat_stream_buffer: hand-built vectors, directed stream sequences and
// randomized streams, all compared every cycle against an edge-numbered reference model.
module tb_concat_stream_buffer;

    localparam int DW    = 16;
    localparam int XL    = 6;
    localparam int HL    = 64;
    localparam int AW    = 8;
    localparam int DEPTH = XL + HL;

    typedef struct {
        logic          xe;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        logic          he;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        logic          sw;
        logic          rs;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  e_bank;
        logic  e_busy;
        logic  e_valid;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          x_wr_en;
    logic [AW-1:0] x_wr_addr;
    logic [DW-1:0] x_wr_data;
    logic          h_wr_en;
    logic [AW-1:0] h_wr_addr;
    logic [DW-1:0] h_wr_data;
    logic          swap;
    logic          rd_start;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          rd_busy;
    logic          wr_bank;

    concat_stream_buffer #(
        .DATA_WIDTH(DW),
        .X_LEN     (XL),
        .H_LEN     (HL),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x_wr_en  (x_wr_en),
        .x_wr_addr(x_wr_addr),
        .x_wr_data(x_wr_data),
        .h_wr_en  (h_wr_en),
        .h_wr_addr(h_wr_addr),
        .h_wr_data(h_wr_data),
        .swap     (swap),
        .rd_start (rd_start),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .rd_busy  (rd_busy),
        .wr_bank  (wr_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stream accepted at edge m_start owns edges m_start+1 .. m_start+DEPTH.
    logic [DW-1:0] mmem [2][DEPTH];
    logic [DW-1:0] snap [DEPTH];
    logic [DW-1:0] m_data;
    logic          m_bank, m_pend, m_active, m_valid, m_last, m_busy;
    int            m_start, edge_n;

    int            n_cmp, n_bad;
    logic [DW-1:0] got [DEPTH];
    int            nwords, toggles, last_idx;
    logic          toggle_at_last;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic modelReset();
        m_bank   = 1'b0;
        m_pend   = 1'b0;
        m_active = 1'b0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        m_busy   = 1'b0;
        m_data   = '0;
    endtask

    task automatic modelEdge();
        logic in_stream, at_end, toggle;
        edge_n++;
        in_stream = m_active && (edge_n > m_start) && (edge_n <= m_start + DEPTH);
        at_end    = m_active && (edge_n == m_start + DEPTH);
        if (x_wr_en && int'(x_wr_addr) < XL) mmem[m_bank][int'(x_wr_addr)] = x_wr_data;
        if (h_wr_en && int'(h_wr_addr) < HL) mmem[m_bank][XL + int'(h_wr_addr)] = h_wr_data;
        m_valid = in_stream;
        m_last  = at_end;
        if (in_stream) m_data = snap[edge_n - m_start - 1];
        toggle = (!in_stream && swap) || (at_end && (m_pend || swap));
        if (in_stream && !at_end && swap) m_pend = 1'b1;
        if (at_end) m_pend = 1'b0;
        if (toggle) m_bank = ~m_bank;
        if (rd_start && (!in_stream || at_end)) begin
            m_active = 1'b1;
            m_start  = edge_n;
            for (int i = 0; i < DEPTH; i++) snap[i] = mmem[~m_bank][i];
        end else if (at_end) begin
            m_active = 1'b0;
        end
        m_busy = m_active && (edge_n >= m_start) && (edge_n < m_start + DEPTH);
    endtask

    function automatic stim_t noStim();
        stim_t s;
        s.xe = 1'b0; s.xa = '0; s.xd = '0;
        s.he = 1'b0; s.ha = '0; s.hd = '0;
        s.sw = 1'b0; s.rs = 1'b0;
        return s;
    endfunction

    function automatic vec_t mkVec(input logic xe, input logic [AW-1:0] xa, input logic [DW-1:0] xd,
                                   input logic he, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                                   input logic sw, input logic eb, input logic ebusy, input logic ev);
        vec_t v;
        v.s      = noStim();
        v.s.xe   = xe; v.s.xa = xa; v.s.xd = xd;
        v.s.he   = he; v.s.ha = ha; v.s.hd = hd;
        v.s.sw   = sw;
        v.e_bank = eb; v.e_busy = ebusy; v.e_valid = ev;
        return v;
    endfunction

    // Inputs are held across one rising edge, the model steps on that edge, outputs are read 1 ns later.
    task automatic applyStimulus(input stim_t s);
        x_wr_en = s.xe; x_wr_addr = s.xa; x_wr_data = s.xd;
        h_wr_en = s.he; h_wr_addr = s.ha; h_wr_data = s.hd;
        swap = s.sw; rd_start = s.rs;
        @(posedge clk);
        modelEdge();
        #1;
        x_wr_en = 1'b0; x_wr_addr = '0; x_wr_data = '0;
        h_wr_en = 1'b0; h_wr_addr = '0; h_wr_data = '0;
        swap = 1'b0; rd_start = 1'b0;
    endtask

    task automatic checkOutput();
        cmp("rd_valid", 32'(rd_valid), 32'(m_valid));
        cmp("rd_last",  32'(rd_last),  32'(m_last));
        cmp("rd_busy",  32'(rd_busy),  32'(m_busy));
        cmp("wr_bank",  32'(wr_bank),  32'(m_bank));
        cmp("rd_data",  32'(rd_data),  32'(m_data));
    endtask

    task automatic randomStim(output stim_t s);
        s    = noStim();
        s.xe = 1'($urandom_range(0, 1));
        s.xa = AW'($urandom_range(0, XL + 1));
        s.xd = DW'($urandom);
        s.he = 1'($urandom_range(0, 1));
        s.ha = AW'($urandom_range(0, HL + 2));
        s.hd = DW'($urandom);
    endtask

    // mode 0: no writes, 1: full fill of the write bank (h[0] = 0x1234), 2: random writes.
    task automatic streamRun(input logic do_start, input logic with_swap, input int mode,
                             input int sw1, input int sw2, input int force_c,
                             input logic [DW-1:0] force_d, input logic restart, input int abort_at);
        stim_t s;
        logic  prev_bank;
        int    c;
        nwords = 0; toggles = 0; toggle_at_last = 1'b0; last_idx = -1;
        if (do_start) begin
            s = noStim();
            s.rs = 1'b1;
            s.sw = with_swap;
            applyStimulus(s);
            checkOutput();
        end
        c = 0;
        while (nwords < DEPTH && c < DEPTH + 8) begin
            s = noStim();
            if (mode == 1) begin
                if (c < XL) begin s.xe = 1'b1; s.xa = AW'(c); s.xd = DW'($urandom); end
                if (c < HL) begin s.he = 1'b1; s.ha = AW'(c); s.hd = (c == 0) ? 16'h1234 : DW'($urandom); end
            end else if (mode == 2) begin
                randomStim(s);
            end
            if (c == force_c) begin s.he = 1'b1; s.ha = '0; s.hd = force_d; end
            if ((sw1 >= 0 && nwords - 1 == sw1) || (sw2 >= 0 && nwords - 1 == sw2)) s.sw = 1'b1;
            if (restart && nwords == DEPTH - 1) s.rs = 1'b1;
            prev_bank = wr_bank;
            applyStimulus(s);
            checkOutput();
            if (rd_valid === 1'b1) begin
                got[nwords] = rd_data;
                if (rd_last === 1'b1) last_idx = nwords;
                nwords++;
            end
            if (wr_bank !== prev_bank) begin
                toggles++;
                if (rd_last === 1'b1) toggle_at_last = 1'b1;
            end
            if (abort_at >= 0 && nwords == abort_at + 1) begin
                rst = 1'b1;
                #1;
                modelReset();
                checkOutput();
                cmp("abort_valid", 32'(rd_valid), 32'd0);
                cmp("abort_busy",  32'(rd_busy),  32'd0);
                cmp("abort_bank",  32'(wr_bank),  32'd0);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            c++;
        end
        if (abort_at < 0) cmp("stream_words", 32'(nwords), 32'(DEPTH));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t         s;
        vec_t          vecs [6];
        logic [DW-1:0] e;
        logic          pend_restart;
        int            gap;

        n_cmp = 0; n_bad = 0; edge_n = 0; m_start = 0;
        rst = 1'b1;
        x_wr_en = 1'b0; x_wr_addr = '0; x_wr_data = '0;
        h_wr_en = 1'b0; h_wr_addr = '0; h_wr_data = '0;
        swap = 1'b0; rd_start = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Fill bank 0; x[5] and h[63] get placeholders that the vector table overwrites.
        for (int j = 0; j < HL; j++) begin
            s = noStim();
            s.he = 1'b1; s.ha = AW'(j); s.hd = (j == HL - 1) ? '0 : DW'(-(j + 1));
            if (j < XL) begin s.xe = 1'b1; s.xa = AW'(j); s.xd = (j == XL - 1) ? '0 : DW'(j + 1); end
            applyStimulus(s);
            checkOutput();
        end

        vecs[0] = mkVec(1'b1, 8'd6, 16'hAAAA, 1'b1, 8'd64,  16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1] = mkVec(1'b1, 8'd5, 16'h0006, 1'b1, 8'd63,  16'hFFC0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2] = mkVec(1'b0, 8'd0, 16'h0000, 1'b0, 8'd0,   16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[3] = mkVec(1'b1, 8'd7, 16'hCCCC, 1'b1, 8'd200, 16'hDDDD, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[4] = mkVec(1'b0, 8'd0, 16'h0000, 1'b0, 8'd0,   16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5] = mkVec(1'b0, 8'd0, 16'h0000, 1'b0, 8'd0,   16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].s);
            checkOutput();
            cmp("vec_bank",  32'(wr_bank),  32'(vecs[i].e_bank));
            cmp("vec_busy",  32'(rd_busy),  32'(vecs[i].e_busy));
            cmp("vec_valid", 32'(rd_valid), 32'(vecs[i].e_valid));
        end

        // Stream bank 0 (1..6, -1..-64) while bank 1 is filled.
        streamRun(1'b1, 1'b0, 1, -1, -1, -1, '0, 1'b0, -1);
        for (int i = 0; i < DEPTH; i++) begin
            e = (i < XL) ? DW'(i + 1) : DW'(-(i - XL + 1));
            cmp("fill_word", 32'(got[i]), 32'(e));
        end
        cmp("fill_last_idx", 32'(last_idx), 32'(DEPTH - 1));
        applyStimulus(noStim());
        checkOutput();
        cmp("busy_after", 32'(rd_busy), 32'd0);
        cmp("hold_data",  32'(rd_data), 32'h0000FFC0);

        // Same-cycle swap + start reads the bank just filled; h[0]=0x7FFF goes to the other bank.
        streamRun(1'b1, 1'b1, 0, -1, -1, 3, 16'h7FFF, 1'b0, -1);
        cmp("pp_word6", 32'(got[6]), 32'h00001234);
        cmp("pp_bank",  32'(wr_bank), 32'd0);

        // Two swaps mid-stream collapse to one toggle on the last word; back-to-back restart.
        streamRun(1'b1, 1'b1, 0, 5, 20, -1, '0, 1'b1, -1);
        cmp("pp2_word6",      32'(got[6]), 32'h00007FFF);
        cmp("pp2_word0",      32'(got[0]), 32'h00000001);
        cmp("pp2_word7",      32'(got[7]), 32'h0000FFFE);
        cmp("defer_toggles",  32'(toggles), 32'd1);
        cmp("defer_at_last",  32'(toggle_at_last), 32'd1);
        cmp("defer_bank",     32'(wr_bank), 32'd0);
        streamRun(1'b0, 1'b0, 2, -1, -1, -1, '0, 1'b0, -1);
        cmp("restart_word6",  32'(got[6]), 32'h00001234);

        // Reset after word 10, then restart on the first edge out of reset.
        streamRun(1'b1, 1'b1, 0, -1, -1, -1, '0, 1'b0, 10);
        streamRun(1'b1, 1'b0, 2, -1, -1, -1, '0, 1'b0, -1);

        pend_restart = 1'b0;
        for (int r = 0; r < 8; r++) begin
            logic rs_now;
            if (!pend_restart) begin
                gap = $urandom_range(0, 4);
                for (int g = 0; g < gap; g++) begin
                    randomStim(s);
                    s.sw = ($urandom_range(0, 3) == 0);
                    applyStimulus(s);
                    checkOutput();
                end
            end
            rs_now = 1'($urandom_range(0, 1));
            streamRun(~pend_restart, 1'($urandom_range(0, 1)), 2,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEPTH - 1)) : -1,
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEPTH - 1)) : -1,
                      -1, '0, rs_now, -1);
            pend_restart = rs_now;
        end
        if (pend_restart) streamRun(1'b0, 1'b0, 0, -1, -1, -1, '0, 1'b0, -1);
        repeat (2) begin
            applyStimulus(noStim());
            checkOutput();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
